// File: rtl/timer_core_pkg.sv
// Shared widths and types for the machine timer core.
package timer_core_pkg;

    localparam int unsigned MTIME_W     = 64;
    localparam int unsigned PRESCALER_W = 12;
    localparam int unsigned STEP_W      = 8;

    typedef logic [MTIME_W-1:0]     mtime_t;
    typedef logic [PRESCALER_W-1:0] presc_t;
    typedef logic [STEP_W-1:0]      step_t;

endpackage

// File: rtl/timer_prescaler.sv
// Tick divider: counts clocks and strobes tick once every prescaler+1 cycles.
module timer_prescaler
    import timer_core_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   active_i,
    input  logic [PRESCALER_W-1:0] prescaler_i,
    output logic                   tick_o
);

    presc_t tick_count_q;
    presc_t tick_count_d;

    // Tick fires on >= so that lowering the prescaler below the running count
    // still produces a tick immediately instead of waiting for a 12-bit wrap.
    always_comb begin
        tick_o = active_i && (tick_count_q >= prescaler_i) && !rst_i;
    end

    // Next count: cleared while idle or on a tick, otherwise free-running increment.
    always_comb begin
        tick_count_d = tick_count_q + presc_t'(1);
        if (!active_i || tick_o) begin
            tick_count_d = '0;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_count_q <= '0;
        end else begin
            tick_count_q <= tick_count_d;
        end
    end

endmodule

// File: rtl/timer_core.sv
// Machine timer core: prescaled tick, next-mtime adder and per-hart compare.
module timer_core
    import timer_core_pkg::*;
#(
    parameter int unsigned N = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   active,
    input  logic [PRESCALER_W-1:0] prescaler,
    input  logic [STEP_W-1:0]      step,
    output logic                   tick,
    output logic [MTIME_W-1:0]     mtime_d,
    input  logic [MTIME_W-1:0]     mtime,
    input  logic [MTIME_W-1:0]     mtimecmp [N],
    output logic [N-1:0]           intr
);

    timer_prescaler u_prescaler (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .active_i    (active),
        .prescaler_i (prescaler),
        .tick_o      (tick)
    );

    // Next mtime value; wraps modulo 2^64, the external register samples it on tick.
    always_comb begin
        mtime_d = mtime + {{(MTIME_W-STEP_W){1'b0}}, step};
    end

    for (genvar g = 0; g < N; g++) begin : g_intr
        // Level interrupt per hart: inclusive unsigned compare, gated by active.
        always_comb begin
            intr[g] = active && (mtime >= mtimecmp[g]);
        end
    end

endmodule

// File: tb/tb_timer_core.sv
// Randomized scoreboard bench for timer_core with a behavioural reference model.
module tb_timer_core;

    localparam int unsigned NH = 4;

    logic        clk;
    logic        rst;
    logic        active;
    logic [11:0] prescaler;
    logic [7:0]  step;
    logic        tick;
    logic [63:0] mtime_d;
    logic [63:0] mtime;
    logic [63:0] cmp [NH];
    logic [NH-1:0] intr;

    timer_core #(.N(NH)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .active    (active),
        .prescaler (prescaler),
        .step      (step),
        .tick      (tick),
        .mtime_d   (mtime_d),
        .mtime     (mtime),
        .mtimecmp  (cmp),
        .intr      (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          tick;
        logic [63:0]   md;
        logic [NH-1:0] intr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: cycles elapsed since the last restart of the divider.
    int unsigned elapsed   = 0;
    bit          prev_stop = 1'b1;

    // Monitor: outputs are always valid, so compare mid-cycle whenever an expectation is queued.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (tick !== e.tick) begin
                failures++;
                $display("FAIL tick: got %b expected %b at %0t", tick, e.tick, $time);
            end
            checks++;
            if (mtime_d !== e.md) begin
                failures++;
                $display("FAIL mtime_d: got %h expected %h at %0t", mtime_d, e.md, $time);
            end
            checks++;
            if (intr !== e.intr) begin
                failures++;
                $display("FAIL intr: got %b expected %b at %0t", intr, e.intr, $time);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // One clock of stimulus; optional asynchronous reset pulse that avoids every clock edge.
    task automatic cycle(input logic r, input logic a, input logic [11:0] p, input logic [7:0] s,
                         input logic [63:0] mt, input logic [63:0] c0, input logic [63:0] c1,
                         input logic [63:0] c2, input logic [63:0] c3, input bit pulse);
        exp_t e;
        @(posedge clk);
        // A tick, idle or reset in the previous cycle restarts the count; otherwise one more cycle elapses.
        if (prev_stop) elapsed = 0;
        else elapsed = (elapsed + 1) % 4096;
        #1;
        rst = r; active = a; prescaler = p; step = s; mtime = mt;
        cmp[0] = c0; cmp[1] = c1; cmp[2] = c2; cmp[3] = c3;
        if (pulse) begin
            #1 rst = 1'b1;
            #1 chk("tick_in_reset", {63'b0, tick}, 64'd0);
            rst = 1'b0;
            elapsed = 0;
        end
        e.tick = a && !r && (elapsed >= int'(p));
        e.md   = mt + 64'(s);
        for (int i = 0; i < int'(NH); i++) begin
            logic [63:0] c;
            case (i)
                0: c = c0;
                1: c = c1;
                2: c = c2;
                default: c = c3;
            endcase
            e.intr[i] = a && (mt >= c);
        end
        exp_q.push_back(e);
        prev_stop = r || !a || e.tick;
    endtask

    logic [63:0] ones;
    int          tick_seen;

    initial begin
        logic [11:0] cur_p;
        logic [63:0] mt;
        logic [63:0] c [NH];
        ones = '1;
        rst = 1'b1; active = 1'b0; prescaler = '0; step = '0; mtime = '0;
        for (int i = 0; i < int'(NH); i++) cmp[i] = '0;

        // Reset state
        repeat (3) cycle(1, 0, 12'd3, 8'd1, 64'd80, 64'd10, 64'd10, 64'd10, 64'd10, 0);
        // Divide-by-4 pattern after reset release
        repeat (12) cycle(0, 1, 12'd3, 8'd1, 64'd80, 64'd200, 64'd200, 64'd200, 64'd200, 0);
        // Adder incl. wrap
        cycle(0, 1, 12'd3, 8'd1, 64'd80, 64'd200, 64'd200, 64'd200, 64'd200, 0);
        #1 chk("mtime_d_81", mtime_d, 64'd81);
        cycle(0, 1, 12'd3, 8'd1, ones, 64'd200, 64'd200, 64'd200, 64'd200, 0);
        #1 chk("mtime_d_wrap", mtime_d, 64'd0);
        cycle(0, 1, 12'd3, 8'd0, 64'd1234, 64'd200, 64'd200, 64'd200, 64'd200, 0);
        // Inclusive compare, immediate deassert/reassert
        cycle(0, 1, 12'd3, 8'd1, 64'd80, 64'd10, 64'd200, 64'd200, 64'd200, 0);
        cycle(0, 1, 12'd3, 8'd1, 64'd80, 64'd80, 64'd200, 64'd200, 64'd200, 0);
        cycle(0, 1, 12'd3, 8'd1, 64'd80, 64'd81, 64'd200, 64'd200, 64'd200, 0);
        cycle(0, 1, 12'd3, 8'd1, 64'd80, 64'd2, 64'd200, 64'd200, 64'd200, 0);
        // Inactive masks everything
        repeat (4) cycle(0, 0, 12'd0, 8'd1, 64'd80, 64'd10, 64'd10, 64'd10, 64'd10, 0);
        // Prescaler 0 with an asynchronous reset pulse mid-run
        repeat (3) cycle(0, 1, 12'd0, 8'd1, 64'd5, 64'd9, 64'd9, 64'd9, 64'd9, 0);
        cycle(0, 1, 12'd0, 8'd1, 64'd5, 64'd9, 64'd9, 64'd9, 64'd9, 1);
        repeat (3) cycle(0, 1, 12'd0, 8'd1, 64'd5, 64'd9, 64'd9, 64'd9, 64'd9, 0);
        // Partial count discarded by a pulse
        repeat (3) cycle(0, 1, 12'd5, 8'd1, 64'd5, 64'd9, 64'd9, 64'd9, 64'd9, 0);
        cycle(0, 1, 12'd5, 8'd1, 64'd5, 64'd9, 64'd9, 64'd9, 64'd9, 1);
        repeat (8) cycle(0, 1, 12'd5, 8'd1, 64'd5, 64'd9, 64'd9, 64'd9, 64'd9, 0);
        // Prescaler lowered below the running count
        repeat (6) cycle(0, 1, 12'd7, 8'd1, 64'd5, 64'd9, 64'd9, 64'd9, 64'd9, 0);
        repeat (4) cycle(0, 1, 12'd2, 8'd1, 64'd5, 64'd9, 64'd9, 64'd9, 64'd9, 0);
        // Four harts
        cycle(0, 1, 12'd2, 8'd1, 64'd100, 64'd50, 64'd100, 64'd101, 64'd0, 0);
        #1 chk("intr_4h", 64'(intr), 64'b1011);

        // Randomized phase
        cur_p = 12'd3;
        for (int n = 0; n < 600; n++) begin
            logic r;
            logic a;
            bit   pl;
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 5))
                    0: cur_p = 12'd0;
                    1: cur_p = 12'd4095;
                    default: cur_p = 12'($urandom_range(0, 6));
                endcase
            end
            r  = ($urandom_range(0, 40) == 0);
            a  = ($urandom_range(0, 9) != 0);
            pl = !r && ($urandom_range(0, 30) == 0);
            case ($urandom_range(0, 3))
                0: mt = ones;
                1: mt = 64'($urandom_range(0, 300));
                default: mt = {$urandom, $urandom};
            endcase
            for (int i = 0; i < int'(NH); i++) begin
                case ($urandom_range(0, 4))
                    0: c[i] = mt;
                    1: c[i] = mt + 64'd1;
                    2: c[i] = mt - 64'd1;
                    3: c[i] = '0;
                    default: c[i] = {$urandom, $urandom};
                endcase
            end
            cycle(r, a, cur_p, 8'($urandom), mt, c[0], c[1], c[2], c[3], pl);
        end

        tick_seen = 0;
        while (exp_q.size() > 0 && tick_seen < 10) begin
            @(negedge clk);
            tick_seen++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
